// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Shared UART types and helpers for the transmitter and the PROM-loading
// receiver.
//   tx_state_t      transmitter FSM states (PARITY is used only when the
//                   parity option is compiled in)
//   FRAME_DATA_BITS data bits per frame
//   baud_divider()  clock cycles per line bit (integer division)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int FRAME_DATA_BITS = 8;

  function automatic int baud_divider(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Interface: uart_tx_fifo_if
// Byte handshake and line-side status of the UART transmitter.
//   tx_data_i     byte offered by the source
//   tx_valid_i    byte offered; held with the data until accepted
//   tx_ready_o    transmitter FIFO can accept
//   tx_o          serial line, idle high
//   busy_o        frame in progress or FIFO non-empty
//   fifo_level_o  FIFO occupancy
// master: the byte source (CPU io_out path); slave: uart_tx_fifo.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [FRAME_DATA_BITS-1:0] tx_data_i;
  logic                       tx_valid_i;
  logic                       tx_ready_o;
  logic                       tx_o;
  logic                       busy_o;
  logic [LEVEL_W-1:0]         fifo_level_o;

  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, tx_o, busy_o, fifo_level_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, tx_o, busy_o, fifo_level_o
  );

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Module: byte_fifo
// Small synchronous FIFO with asynchronous active-high reset.
//   clk, reset   clock / async reset (flushes contents)
//   push, push_data  write request; ignored while full
//   pop, pop_data    read request; pop_data shows the head (valid when !empty)
//   full, empty, level  status decoded from registered occupancy
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FRAME_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             push_en;
  logic             pop_en;

  assign full     = (level_reg == FULL_LEVEL);
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  // Head is read straight from the register array so the consumer can load
  // it on the same edge that pops it.
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_en, pop_en})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Module: uart_tx_fifo
// Buffered serial transmitter. Bytes accepted on the bus handshake are queued
// in a byte_fifo and sent LSB first as 8N1 frames (8E1 when the macro
// UART_TX_PARITY_EN is defined) at DIVIDER = CLOCK_HZ/BAUD clocks per bit.
//   clk    clock, all state on posedge
//   reset  asynchronous active-high; flushes the FIFO and aborts the frame
//   bus    uart_tx_fifo_if.slave: tx_data_i/tx_valid_i/tx_ready_o handshake,
//          tx_o line, busy_o, fifo_level_o
// Frames follow each other with no idle gap while the FIFO holds data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 625,
  parameter int BAUD       = 78,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int DIVIDER = baud_divider(CLOCK_HZ, BAUD);
  localparam int CNT_W   = (DIVIDER < 2) ? 1 : $clog2(DIVIDER);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
  localparam logic [2:0]       IDX_LAST = 3'(FRAME_DATA_BITS - 1);

  if (DIVIDER < 2) begin : g_bad_divider
    $error("uart_tx_fifo: CLOCK_HZ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_t                  state_reg;
  logic [CNT_W-1:0]           baud_cnt_reg;
  logic [2:0]                 bit_idx_reg;
  logic [FRAME_DATA_BITS-1:0] shift_reg;
  logic                       tx_reg;
`ifdef UART_TX_PARITY_EN
  logic                       parity_reg;
`endif

  logic [FRAME_DATA_BITS-1:0] fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [LEVEL_W-1:0]         fifo_level;
  logic                       bit_end;
  logic                       pop_start;

  assign bit_end = (baud_cnt_reg == CNT_LAST);
  // A new frame starts from IDLE, or straight out of the last stop cycle.
  assign pop_start = !fifo_empty &&
                     ((state_reg == IDLE) || (state_reg == STOP && bit_end));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.tx_valid_i),
    .push_data (bus.tx_data_i),
    .pop       (pop_start),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop_start) begin
            state_reg    <= START;
            baud_cnt_reg <= '0;
            shift_reg    <= fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= ^fifo_head;
`endif
            tx_reg       <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= DATA;
            tx_reg       <= shift_reg[0];
            shift_reg    <= {1'b0, shift_reg[FRAME_DATA_BITS-1:1]};
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == IDX_LAST) begin
              bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
              state_reg   <= PARITY;
              tx_reg      <= parity_reg;
`else
              state_reg   <= STOP;
              tx_reg      <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[FRAME_DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= STOP;
            tx_reg       <= 1'b1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (pop_start) begin
              // Back-to-back: the next start bit follows the stop bit directly.
              state_reg <= START;
              shift_reg <= fifo_head;
`ifdef UART_TX_PARITY_EN
              parity_reg <= ^fifo_head;
`endif
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg    <= IDLE;
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_o         = tx_reg;
  assign bus.tx_ready_o   = !fifo_full;
  assign bus.busy_o       = (state_reg != IDLE) || !fifo_empty;
  assign bus.fifo_level_o = fifo_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table of single-byte frames, directed
// back-to-back / full-FIFO / reset sequences, a divider sweep instance, and a
// randomized run checked by a line-decoding receiver model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 2;
  localparam int D1    = 625 / 78;
  localparam int D2    = 1000 / 100;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus1 ();
  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus2 ();

  uart_tx_fifo #(.CLOCK_HZ(625), .BAUD(78), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  uart_tx_fifo #(.CLOCK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic line(input int which);
    return (which != 0) ? bus2.tx_o : bus1.tx_o;
  endfunction

  // Expected line level of bit k of a frame; bits[0] is the first data bit sent.
  function automatic logic frame_bit(input logic [0:7] bits, input logic par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return bits[k-1];
    if (NB == 11 && k == 9) return par;
    return 1'b1;
  endfunction

  task automatic set_in(input int which, input logic v, input logic [7:0] d);
    if (which != 0) begin bus2.tx_valid_i = v; bus2.tx_data_i = d; end
    else begin bus1.tx_valid_i = v; bus1.tx_data_i = d; end
  endtask

  // Caller positioned so the next negedge is the first cycle of the start bit.
  task automatic expect_frame(input int which, input int div, input logic [0:7] bits,
                              input logic par, input string name);
    logic e, s, obs;
    for (int k = 0; k < NB; k++) begin
      e = frame_bit(bits, par, k);
      obs = 1'bx;
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        s = line(which);
        if (c == 0 || (s !== e && obs === e)) obs = s;
      end
      check($sformatf("%s bit%0d", name, k), obs, e);
    end
  endtask

  // Offer a byte; returns #1 after the accepting posedge with valid dropped.
  task automatic push_byte(input int which, input logic [7:0] d);
    logic r;
    logic ok;
    ok = 1'b0;
    set_in(which, 1'b1, d);
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      r = (which != 0) ? bus2.tx_ready_o : bus1.tx_ready_o;
      @(posedge clk);
      #1;
      if (r) ok = 1'b1;
    end
    set_in(which, 1'b0, d);
    check($sformatf("push %02h accepted", d), ok, 1'b1);
  endtask

  task automatic wait_idle(input int which);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge clk);
      if (which != 0) idle = !bus2.busy_o && bus2.tx_o;
      else            idle = !bus1.busy_o && bus1.tx_o;
    end
    check("wait idle", idle, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- receiver model for the randomized run ----------------
  logic       mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int         pushes = 0;
  int         starts = 0;
  int         frames = 0;
  int         sc_bad = 0;
  logic       in_frame = 1'b0;
  int         pos;
  int         glitch;
  logic       cur;
  logic       fbits [0:10];

  task automatic finish_frame();
    logic [7:0] v;
    logic [7:0] want;
    v = '0;
    for (int b = 0; b < 8; b++) v[b] = fbits[1+b];
    frames++;
    $display("rx frame %0d data=%02h", frames, v);
    check("rand glitch-free bits", glitch, 0);
    check("rand stop bit", fbits[NB-1], 1'b1);
    if (NB == 11) check("rand parity", fbits[9], ^v);
    if (exp_q.size() == 0) begin
      check("rand spurious frame", 1, 0);
    end else begin
      want = exp_q.pop_front();
      check("rand data order", v, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic active;
      int   exp_level;
      if (!in_frame && bus1.tx_o === 1'b0) begin
        in_frame = 1'b1; pos = 0; glitch = 0; starts++;
      end
      active = in_frame;
      if (in_frame) begin
        if (pos % D1 == 0) begin cur = bus1.tx_o; fbits[pos / D1] = cur; end
        else if (bus1.tx_o !== cur) glitch++;
        pos++;
        if (pos == NB * D1) begin in_frame = 1'b0; finish_frame(); end
      end
      exp_level = pushes - starts;
      if (int'(bus1.fifo_level_o) != exp_level ||
          bus1.tx_ready_o !== (exp_level != DEPTH) ||
          bus1.busy_o !== (active || exp_level != 0)) sc_bad++;
    end
  end

  // ---------------- table of single frames ----------------
  typedef struct {
    logic [7:0] data;
    logic [0:7] bits;  // transmission order, first data bit leftmost
    logic       par;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int         rate;
    int         j;
    int         lvl_bad;
    logic       seen;
    int         bad;

    tbl[0] = '{8'hA5, 8'b10100101, 1'b0};
    tbl[1] = '{8'h01, 8'b10000000, 1'b1};
    tbl[2] = '{8'h55, 8'b10101010, 1'b0};
    tbl[3] = '{8'h0F, 8'b11110000, 1'b0};
    tbl[4] = '{8'hC3, 8'b11000011, 1'b0};
    tbl[5] = '{8'h07, 8'b11100000, 1'b1};
    tbl[6] = '{8'h80, 8'b00000001, 1'b1};

    reset = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("reset tx", bus1.tx_o, 1'b1);
    check("reset ready", bus1.tx_ready_o, 1'b1);
    check("reset busy", bus1.busy_o, 1'b0);
    check("reset level", bus1.fifo_level_o, 0);
    check("reset tx dut2", bus2.tx_o, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset level", bus1.fifo_level_o, 0);
    check("post-reset tx", bus1.tx_o, 1'b1);

    // Single frames from the table
    for (int i = 0; i < 7; i++) begin
      wait_idle(0);
      push_byte(0, tbl[i].data);
      $display("txn %0d single byte %02h", i, tbl[i].data);
      @(negedge clk);
      check("latency tx still idle", bus1.tx_o, 1'b1);
      check("latency level", bus1.fifo_level_o, 1);
      check("latency busy", bus1.busy_o, 1'b1);
      expect_frame(0, D1, tbl[i].bits, tbl[i].par, $sformatf("tbl%0d", i));
      @(negedge clk);
      check("busy falls after stop", bus1.busy_o, 1'b0);
      check("line idle after stop", bus1.tx_o, 1'b1);
    end

    // Back-to-back 0x00 then 0xFF
    wait_idle(0);
    push_byte(0, 8'h00);
    set_in(0, 1'b1, 8'hFF);
    @(negedge clk);
    check("b2b ready for second", bus1.tx_ready_o, 1'b1);
    @(posedge clk);
    #1 set_in(0, 1'b0, 8'hFF);
    $display("txn b2b bytes 00 ff");
    expect_frame(0, D1, 8'b00000000, 1'b0, "b2b 00");
    expect_frame(0, D1, 8'b11111111, 1'b0, "b2b ff");
    @(negedge clk);
    check("b2b busy end", bus1.busy_o, 1'b0);

    // Full FIFO: 01,02,03 consecutive, 04 held until room
    wait_idle(0);
    push_byte(0, 8'h01);
    set_in(0, 1'b1, 8'h02);
    $display("txn full-fifo bytes 01 02 03 04");
    fork
      begin
        @(posedge clk);
        expect_frame(0, D1, 8'b10000000, 1'b1, "full 01");
        expect_frame(0, D1, 8'b01000000, 1'b1, "full 02");
        expect_frame(0, D1, 8'b11000000, 1'b0, "full 03");
        expect_frame(0, D1, 8'b00100000, 1'b1, "full 04");
      end
      begin
        @(posedge clk);
        #1 bus1.tx_data_i = 8'h03;
        @(posedge clk);
        #1 bus1.tx_data_i = 8'h04;
        @(negedge clk);
        check("full level", bus1.fifo_level_o, 2);
        check("full ready low", bus1.tx_ready_o, 1'b0);
        j = 0; seen = 1'b0; lvl_bad = 0;
        while (!seen && j < 4 * NB * D1) begin
          @(negedge clk);
          j++;
          if (bus1.tx_ready_o) seen = 1'b1;
          else if (bus1.fifo_level_o != 2) lvl_bad++;
        end
        check("full 04 accept wait", j, NB * D1 - 1);
        check("full level held", lvl_bad, 0);
        @(posedge clk);
        #1 set_in(0, 1'b0, 8'h04);
      end
    join
    @(negedge clk);
    check("full busy end", bus1.busy_o, 1'b0);

    // Reset during data bit 3 of 0x55 with 0x66 buffered
    wait_idle(0);
    push_byte(0, 8'h55);
    set_in(0, 1'b1, 8'h66);
    @(posedge clk);
    #1 set_in(0, 1'b0, 8'h66);
    $display("txn reset mid-frame 55 with 66 buffered");
    repeat (4 * D1 + 3) @(negedge clk);
    check("mid-frame tx bit3", bus1.tx_o, 1'b0);
    check("mid-frame level", bus1.fifo_level_o, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset tx", bus1.tx_o, 1'b1);
    check("async reset level", bus1.fifo_level_o, 0);
    check("async reset ready", bus1.tx_ready_o, 1'b1);
    check("async reset busy", bus1.busy_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (3 * NB * D1) begin
      @(negedge clk);
      if (bus1.tx_o !== 1'b1 || bus1.busy_o !== 1'b0) bad++;
    end
    check("no frames after reset", bad, 0);
    check("level after reset", bus1.fifo_level_o, 0);

    // Divider sweep on the 1000/100 instance
    wait_idle(1);
    push_byte(1, 8'hA5);
    $display("txn divider-10 byte a5");
    @(negedge clk);
    check("div10 latency", bus2.tx_o, 1'b1);
    expect_frame(1, D2, 8'b10100101, 1'b0, "div10 a5");
    @(negedge clk);
    check("div10 busy end", bus2.busy_o, 1'b0);

    // Randomized traffic against the receiver model
    wait_idle(0);
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      rate = (cyc < 500) ? 3 : 120;
      if (!bus1.tx_valid_i && $urandom_range(0, rate - 1) == 0) begin
        d = 8'($urandom);
        set_in(0, 1'b1, d);
      end
      @(negedge clk);
      seen = bus1.tx_valid_i && bus1.tx_ready_o;
      @(posedge clk);
      #1;
      if (seen) begin
        exp_q.push_back(bus1.tx_data_i);
        pushes++;
        set_in(0, 1'b0, bus1.tx_data_i);
      end
    end
    set_in(0, 1'b0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = (exp_q.size() == 0) && !in_frame && !bus1.busy_o;
    end
    check("rand drain", seen, 1'b1);
    mon_en = 1'b0;
    check("rand frame count", frames, pushes);
    check("rand level/ready/busy", sc_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
